// File: rtl/udma_pkg.sv
// Shared uDMA constants: L2 port identifiers and the arbiter lock state type.
package udma_pkg;

  localparam logic UDMA_L2_PORT_RO = 1'b0;
  localparam logic UDMA_L2_PORT_WO = 1'b1;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/udma_l2_port_arbiter_fifo.sv
// Non-fall-through FIFO of 1-bit port IDs, one entry per granted-but-unanswered request.
module udma_l2_port_arbiter_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  logic data_i,
  input  logic pop_i,
  output logic data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_en, pop_en;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_en) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop_en)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    if (push_en && !pop_en)      cnt_d = cnt_q + 1'b1;
    else if (!push_en && pop_en) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_en) mem_q[wr_ptr_q] <= data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/udma_l2_port_arbiter.sv
// Merges the uDMA ro and wo L2 ports onto one TCDM master port with round-robin
// arbitration, request locking and ID-tracked response routing.
module udma_l2_port_arbiter
  import udma_pkg::*;
#(
  parameter int L2_DATA_WIDTH   = 32,
  parameter int L2_ADDR_WIDTH   = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                       sys_clk_i,
  input  logic                       sys_rst_ni,

  input  logic                       ro_req_i,
  output logic                       ro_gnt_o,
  input  logic                       ro_wen_i,
  input  logic [L2_ADDR_WIDTH-1:0]   ro_addr_i,
  input  logic [L2_DATA_WIDTH/8-1:0] ro_be_i,
  input  logic [L2_DATA_WIDTH-1:0]   ro_wdata_i,
  output logic                       ro_rvalid_o,
  output logic [L2_DATA_WIDTH-1:0]   ro_rdata_o,

  input  logic                       wo_req_i,
  output logic                       wo_gnt_o,
  input  logic                       wo_wen_i,
  input  logic [L2_ADDR_WIDTH-1:0]   wo_addr_i,
  input  logic [L2_DATA_WIDTH/8-1:0] wo_be_i,
  input  logic [L2_DATA_WIDTH-1:0]   wo_wdata_i,
  output logic                       wo_rvalid_o,
  output logic [L2_DATA_WIDTH-1:0]   wo_rdata_o,

  output logic                       l2_req_o,
  output logic                       l2_wen_o,
  output logic [L2_ADDR_WIDTH-1:0]   l2_addr_o,
  output logic [L2_DATA_WIDTH/8-1:0] l2_be_o,
  output logic [L2_DATA_WIDTH-1:0]   l2_wdata_o,
  input  logic                       l2_gnt_i,
  input  logic                       l2_rvalid_i,
  input  logic [L2_DATA_WIDTH-1:0]   l2_rdata_i,

  output logic                       err_o
);

  // Handshake: a request is accepted in the cycle where l2_req_o & l2_gnt_i;
  // the requester must hold req and fields stable until its own gnt.

  arb_state_e state_q, state_d;
  logic       lock_sel_q, lock_sel_d;
  logic       rr_ptr_q, rr_ptr_d;
  logic       err_q, err_d;

  logic sel;
  logic grant;
  logic fifo_full, fifo_empty, fifo_head, fifo_pop;

  always_comb begin
    if (state_q == ARB_LOCKED)        sel = lock_sel_q;
    else if (ro_req_i && !wo_req_i)   sel = UDMA_L2_PORT_RO;
    else if (wo_req_i && !ro_req_i)   sel = UDMA_L2_PORT_WO;
    else                              sel = rr_ptr_q;
  end

  // fifo_full is registered, so a pop this cycle cannot free a slot for a grant this cycle.
  assign l2_req_o = (ro_req_i | wo_req_i) & ~fifo_full;
  assign grant    = l2_req_o & l2_gnt_i;
  assign ro_gnt_o = grant & (sel == UDMA_L2_PORT_RO);
  assign wo_gnt_o = grant & (sel == UDMA_L2_PORT_WO);

  assign l2_wen_o   = (sel == UDMA_L2_PORT_WO) ? wo_wen_i   : ro_wen_i;
  assign l2_addr_o  = (sel == UDMA_L2_PORT_WO) ? wo_addr_i  : ro_addr_i;
  assign l2_be_o    = (sel == UDMA_L2_PORT_WO) ? wo_be_i    : ro_be_i;
  assign l2_wdata_o = (sel == UDMA_L2_PORT_WO) ? wo_wdata_i : ro_wdata_i;

  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (l2_req_o && !l2_gnt_i) begin
          state_d    = ARB_LOCKED;
          lock_sel_d = sel;
        end
      end
      ARB_LOCKED: begin
        if (l2_gnt_i) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    if (grant) rr_ptr_d = ~sel;
  end

  // Responses return in issue order; the FIFO head names the port that owns the next rvalid.
  assign fifo_pop    = l2_rvalid_i & ~fifo_empty;
  assign ro_rvalid_o = fifo_pop & (fifo_head == UDMA_L2_PORT_RO);
  assign wo_rvalid_o = fifo_pop & (fifo_head == UDMA_L2_PORT_WO);
  assign ro_rdata_o  = l2_rdata_i;
  assign wo_rdata_o  = l2_rdata_i;

  assign err_d = err_q | (l2_rvalid_i & fifo_empty);
  assign err_o = err_q;

  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      state_q    <= ARB_IDLE;
      lock_sel_q <= UDMA_L2_PORT_RO;
      rr_ptr_q   <= UDMA_L2_PORT_RO;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
      rr_ptr_q   <= rr_ptr_d;
      err_q      <= err_d;
    end
  end

  udma_l2_port_arbiter_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) i_id_fifo (
    .clk_i   (sys_clk_i),
    .rst_ni  (sys_rst_ni),
    .push_i  (grant),
    .data_i  (sel),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_udma_l2_port_arbiter.sv
// Randomized and directed bench for udma_l2_port_arbiter against a queue-based model.
module tb_udma_l2_port_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int MAX = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          ro_req, ro_wen, wo_req, wo_wen;
  logic [AW-1:0] ro_addr, wo_addr;
  logic [DW/8-1:0] ro_be, wo_be;
  logic [DW-1:0] ro_wdata, wo_wdata;
  logic          l2_gnt, l2_rvalid;
  logic [DW-1:0] l2_rdata;

  logic          ro_gnt, wo_gnt, ro_rvalid, wo_rvalid;
  logic [DW-1:0] ro_rdata, wo_rdata;
  logic          l2_req, l2_wen, err;
  logic [AW-1:0] l2_addr;
  logic [DW/8-1:0] l2_be;
  logic [DW-1:0] l2_wdata;

  udma_l2_port_arbiter #(
    .L2_DATA_WIDTH(DW), .L2_ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAX)
  ) dut (
    .sys_clk_i(clk), .sys_rst_ni(rst_n),
    .ro_req_i(ro_req), .ro_gnt_o(ro_gnt), .ro_wen_i(ro_wen), .ro_addr_i(ro_addr),
    .ro_be_i(ro_be), .ro_wdata_i(ro_wdata), .ro_rvalid_o(ro_rvalid), .ro_rdata_o(ro_rdata),
    .wo_req_i(wo_req), .wo_gnt_o(wo_gnt), .wo_wen_i(wo_wen), .wo_addr_i(wo_addr),
    .wo_be_i(wo_be), .wo_wdata_i(wo_wdata), .wo_rvalid_o(wo_rvalid), .wo_rdata_o(wo_rdata),
    .l2_req_o(l2_req), .l2_wen_o(l2_wen), .l2_addr_o(l2_addr), .l2_be_o(l2_be),
    .l2_wdata_o(l2_wdata), .l2_gnt_i(l2_gnt), .l2_rvalid_i(l2_rvalid), .l2_rdata_i(l2_rdata),
    .err_o(err)
  );

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [0:0] exp_q[$];   // port IDs awaiting a response, oldest first
  logic m_pref;           // port favoured when both request
  int   m_held;           // port whose stalled request owns the bus, -1 if none
  logic m_err;
  logic m_req;
  logic m_pick;
  logic last_gnt_ro, last_gnt_wo;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_pref = 1'b0;
    m_held = -1;
    m_err  = 1'b0;
    last_gnt_ro = 1'b0;
    last_gnt_wo = 1'b0;
  endtask

  task automatic check_all();
    logic full, rv_head;
    full   = (exp_q.size() == MAX);
    m_req  = (ro_req | wo_req) & ~full;
    if (m_held >= 0)           m_pick = m_held[0];
    else if (ro_req && !wo_req) m_pick = 1'b0;
    else if (wo_req && !ro_req) m_pick = 1'b1;
    else                        m_pick = m_pref;
    chk("l2_req", l2_req, m_req);
    chk("ro_gnt", ro_gnt, m_req & l2_gnt & (m_pick == 1'b0));
    chk("wo_gnt", wo_gnt, m_req & l2_gnt & (m_pick == 1'b1));
    if (m_req) begin
      chk("l2_addr",  l2_addr,  m_pick ? wo_addr  : ro_addr);
      chk("l2_wen",   l2_wen,   m_pick ? wo_wen   : ro_wen);
      chk("l2_be",    l2_be,    m_pick ? wo_be    : ro_be);
      chk("l2_wdata", l2_wdata, m_pick ? wo_wdata : ro_wdata);
    end
    rv_head = (exp_q.size() > 0) ? exp_q[0] : 1'b0;
    chk("ro_rvalid", ro_rvalid, l2_rvalid && exp_q.size() > 0 && rv_head == 1'b0);
    chk("wo_rvalid", wo_rvalid, l2_rvalid && exp_q.size() > 0 && rv_head == 1'b1);
    if (ro_rvalid) chk("ro_rdata", ro_rdata, l2_rdata);
    if (wo_rvalid) chk("wo_rdata", wo_rdata, l2_rdata);
    chk("err", err, m_err);
  endtask

  task automatic model_update();
    logic granted;
    granted = m_req & l2_gnt;
    if (l2_rvalid) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      else m_err = 1'b1;
    end
    if (granted) begin
      exp_q.push_back(m_pick);
      m_pref = ~m_pick;
    end
    if (m_held < 0 && m_req && !l2_gnt) m_held = int'(m_pick);
    else if (m_held >= 0 && l2_gnt)     m_held = -1;
    last_gnt_ro = granted & ~m_pick;
    last_gnt_wo = granted & m_pick;
  endtask

  // ---------------- driver tasks ----------------
  task automatic begin_cycle();
    @(negedge clk);
    check_all();
  endtask

  task automatic end_cycle();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ro_req = 0; ro_wen = 0; ro_addr = '0; ro_be = '0; ro_wdata = '0;
    wo_req = 0; wo_wen = 0; wo_addr = '0; wo_be = '0; wo_wdata = '0;
    l2_gnt = 0; l2_rvalid = 0; l2_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("rst_l2_req", l2_req, 0);
    chk("rst_gnts", {ro_gnt, wo_gnt}, 0);
    chk("rst_rvalids", {ro_rvalid, wo_rvalid}, 0);
    chk("rst_rdata", {ro_rdata, wo_rdata}, 0);
    chk("rst_err", err, 0);
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_drive();
    if (!(ro_req && !last_gnt_ro)) begin
      ro_req = ($urandom_range(0, 99) < 60);
      ro_wen = 1'($urandom); ro_addr = $urandom; ro_be = 4'($urandom); ro_wdata = $urandom;
    end
    if (!(wo_req && !last_gnt_wo)) begin
      wo_req = ($urandom_range(0, 99) < 60);
      wo_wen = 1'($urandom); wo_addr = $urandom; wo_be = 4'($urandom); wo_wdata = $urandom;
    end
    l2_gnt    = ($urandom_range(0, 99) < 70);
    l2_rvalid = (exp_q.size() > 0) && ($urandom_range(0, 99) < 50);
    l2_rdata  = $urandom;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    model_clear();
    do_reset();

    // Both ports request continuously: grants alternate, rvalid follows each grant by one cycle.
    ro_req = 1; wo_req = 1; ro_addr = 32'h1000; wo_addr = 32'h2000; l2_gnt = 1;
    for (int i = 0; i < 8; i++) begin
      l2_rvalid = (i > 0);
      l2_rdata  = 32'hA000 + i;
      begin_cycle();
      chk("alt_ro_gnt", ro_gnt, (i % 2) == 0);
      chk("alt_wo_gnt", wo_gnt, (i % 2) == 1);
      if (i > 0) chk("alt_ro_rvalid", ro_rvalid, (i % 2) == 1);
      end_cycle();
    end
    do_reset();

    // ro stalls unground; wo rising meanwhile must not steal the locked bus.
    ro_req = 1; ro_addr = 32'hCAFE0000; l2_gnt = 0;
    for (int i = 0; i < 3; i++) begin
      begin_cycle();
      chk("lock_addr", l2_addr, 32'hCAFE0000);
      chk("lock_no_gnt", ro_gnt, 0);
      end_cycle();
    end
    wo_req = 1; wo_addr = 32'hBEEF0000;
    begin_cycle();
    chk("lock_hold_addr", l2_addr, 32'hCAFE0000);
    end_cycle();
    l2_gnt = 1;
    begin_cycle();
    chk("lock_first_ro", ro_gnt, 1);
    chk("lock_first_addr", l2_addr, 32'hCAFE0000);
    end_cycle();
    ro_req = 0;
    begin_cycle();
    chk("lock_next_wo", wo_gnt, 1);
    chk("lock_next_addr", l2_addr, 32'hBEEF0000);
    end_cycle();
    do_reset();

    // Fill the outstanding FIFO, then free one slot.
    ro_req = 1; ro_addr = 32'h40; l2_gnt = 1;
    for (int i = 0; i < MAX; i++) begin
      begin_cycle();
      chk("fill_gnt", ro_gnt, 1);
      end_cycle();
    end
    begin_cycle();
    chk("full_no_req", l2_req, 0);
    chk("full_no_gnt", {ro_gnt, wo_gnt}, 0);
    end_cycle();
    l2_rvalid = 1; l2_rdata = 32'h55AA;
    begin_cycle();
    chk("full_pop_no_req", l2_req, 0);
    chk("full_pop_rvalid", ro_rvalid, 1);
    end_cycle();
    l2_rvalid = 0;
    begin_cycle();
    chk("after_pop_req", l2_req, 1);
    end_cycle();
    do_reset();

    // Grant and rvalid together with two outstanding; then spurious rvalid sets err.
    ro_req = 1; wo_req = 1; l2_gnt = 1;
    for (int i = 0; i < 2; i++) begin begin_cycle(); end_cycle(); end
    l2_rvalid = 1; l2_rdata = 32'h1234;
    begin_cycle();
    chk("pp_ro_gnt", ro_gnt, 1);
    chk("pp_ro_rvalid", ro_rvalid, 1);
    end_cycle();
    ro_req = 0; wo_req = 0; l2_gnt = 0;
    begin_cycle(); chk("pp_drain_wo", wo_rvalid, 1); end_cycle();
    begin_cycle(); chk("pp_drain_ro", ro_rvalid, 1); end_cycle();
    begin_cycle();
    chk("spur_no_rvalid", {ro_rvalid, wo_rvalid}, 0);
    chk("spur_err_before", err, 0);
    end_cycle();
    l2_rvalid = 0;
    for (int i = 0; i < 3; i++) begin
      begin_cycle(); chk("err_sticky", err, 1); end_cycle();
    end
    do_reset();

    // Reset with three outstanding flushes them; a later rvalid is spurious.
    ro_req = 1; l2_gnt = 1;
    for (int i = 0; i < 3; i++) begin begin_cycle(); end_cycle(); end
    do_reset();
    l2_rvalid = 1;
    begin_cycle();
    chk("flush_no_rvalid", {ro_rvalid, wo_rvalid}, 0);
    end_cycle();
    l2_rvalid = 0;
    begin_cycle(); chk("flush_err", err, 1); end_cycle();
    do_reset();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rand_drive();
      begin_cycle();
      end_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
